// File: rtl/data_mem_responder.sv
// Handshaked load/store responder over an internal 32-bit word array.
// Byte/half/word access with programmable wait states and extended load data.
module data_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int WAIT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int IDX_W = ADDR_W + 2;

    if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
        $error("data_mem_responder: WAIT must be in 0..15");
    end
    if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
        $error("data_mem_responder: ADDR_W must be in 1..29");
    end

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef struct packed {
        logic             we;
        logic [IDX_W-1:0] addr;
        logic [31:0]      wdata;
        logic [1:0]       size;
        logic             uns;
    } req_t;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    req_t        req_in;
    req_t        acc;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH];

    logic              req_err;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [31:0]       rd_word;
    logic [31:0]       shifted;
    logic [31:0]       load_data;
    logic [31:0]       wr_mask;
    logic [31:0]       wr_rep;
    logic [31:0]       wr_word;
    logic              do_access;
    logic              mem_we;

    assign req_in = '{
        we:    req_we,
        addr:  req_addr[IDX_W-1:0],
        wdata: req_wdata,
        size:  req_size,
        uns:   req_unsigned
    };

    assign req_err = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || (req_addr[31:IDX_W] != '0);

    // A zero-wait access happens in the accept cycle, so it must use the live request.
    assign acc      = (state_q == S_IDLE) ? req_in : req_q;
    assign word_idx = acc.addr[IDX_W-1:2];
    assign lane     = acc.addr[1:0];
    assign rd_word  = mem_q[word_idx];
    assign shifted  = rd_word >> {lane, 3'b000};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        load_data = shifted;
        wr_mask   = '1;
        wr_rep    = acc.wdata;
        case (acc.size)
            2'b00: begin
                load_data = {{24{~acc.uns & shifted[7]}}, shifted[7:0]};
                wr_mask   = 32'h0000_00FF << {lane, 3'b000};
                wr_rep    = {4{acc.wdata[7:0]}};
            end
            2'b01: begin
                load_data = {{16{~acc.uns & shifted[15]}}, shifted[15:0]};
                wr_mask   = 32'h0000_FFFF << {lane[1], 4'b0000};
                wr_rep    = {2{acc.wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign wr_word = (rd_word & ~wr_mask) | (wr_rep & wr_mask);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_d = req_in;
                    if (req_err) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (WAIT_CNT == 4'd0) begin
                        do_access = 1'b1;
                        state_d   = S_RESP;
                        err_d     = 1'b0;
                        rdata_d   = acc.we ? '0 : load_data;
                    end else begin
                        cnt_d   = WAIT_CNT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d     = 4'd0;
                    do_access = 1'b1;
                    state_d   = S_RESP;
                    err_d     = 1'b0;
                    rdata_d   = acc.we ? '0 : load_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_we = do_access & acc.we;

    // NOTE: state flops use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array is deliberately not reset; a write is only blocked while reset is high.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[word_idx] <= wr_word;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized bench for data_mem_responder against a byte-addressed
// little-endian memory model.
module tb_data_mem_responder;

    localparam int ADDR_W_P  = 8;
    localparam int WAIT_P    = 2;
    localparam int MEM_BYTES = 4 << ADDR_W_P;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    data_mem_responder #(
        .ADDR_W(ADDR_W_P),
        .WAIT  (WAIT_P)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] mem_m [MEM_BYTES];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0)
            || (a >= 32'(MEM_BYTES));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic uns);
        int     n;
        longint v;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) begin
            v = v + (longint'(mem_m[int'(a) + i]) << (8 * i));
        end
        if (!uns && v >= (64'sd1 <<< (8 * n - 1))) begin
            v = v - (64'sd1 <<< (8 * n));
        end
        return v[31:0];
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] w);
        int n;
        n = 1 << sz;
        for (int i = 0; i < n; i++) begin
            mem_m[int'(a) + i] = 8'(w >> (8 * i));
        end
    endtask

    // One full request/response exchange; the response is held for 'hold' cycles first.
    task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                            input int hold, output logic [31:0] rd);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          lat;
        exp_err = model_err(addr, size);
        exp_rd  = '0;
        if (!exp_err) begin
            if (we) model_store(addr, size, wdata);
            else    exp_rd = model_load(addr, size, uns);
        end
        exp_lat = exp_err ? 1 : WAIT_P + 1;

        @(negedge clk);
        chk({tag, ":req_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        req_we       = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 40);
        chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ":err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, ":rdata"}, rsp_rdata, exp_rd);
        rd = rsp_rdata;

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, ":hold_rdata"}, rsp_rdata, exp_rd);
            chk({tag, ":hold_err"}, 32'(rsp_err), 32'(exp_err));
            chk({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, ":done_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ":done_ready"}, 32'(req_ready), 32'd1);
    endtask

    logic [31:0] rd;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    int          sel;

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        rsp_ready    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset:rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset:rsp_err", 32'(rsp_err), 32'd0);
        chk("reset:rsp_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("reset:req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            transact("init_sw", 1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0, 0, rd);
        end
        transact("sw_pre", 1'b1, 32'h10, 32'h1234_5678, 2'b10, 1'b0, 0, rd);

        // Store to 0x10 aborted by reset while waiting: must never land.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hDEAD_BEEF;
        req_size  = 2'b10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        chk("midrst:rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst:rsp_valid2", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst:req_ready", 32'(req_ready), 32'd1);
        chk("midrst:rsp_err", 32'(rsp_err), 32'd0);
        chk("midrst:rsp_rdata", rsp_rdata, 32'd0);
        transact("midrst_lw", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd);
        chk("midrst:word", rd, 32'h1234_5678);

        transact("sw_10", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, rd);
        transact("lw_10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd);
        chk("lw_10:const", rd, 32'hDEAD_BEEF);
        transact("lb_13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, rd);
        chk("lb_13:const", rd, 32'hFFFF_FFDE);
        transact("lbu_13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, rd);
        chk("lbu_13:const", rd, 32'h0000_00DE);
        transact("lh_10", 1'b0, 32'h10, 32'h0, 2'b01, 1'b0, 0, rd);
        chk("lh_10:const", rd, 32'hFFFF_BEEF);
        transact("lhu_12", 1'b0, 32'h12, 32'h0, 2'b01, 1'b1, 0, rd);
        chk("lhu_12:const", rd, 32'h0000_DEAD);
        transact("sb_11", 1'b1, 32'h11, 32'hFFFF_FF55, 2'b00, 1'b0, 0, rd);
        transact("lw_10b", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd);
        chk("lw_10b:const", rd, 32'hDEAD_55EF);

        transact("err_lw12", 1'b0, 32'h12, 32'h0, 2'b10, 1'b0, 0, rd);
        transact("err_lh01", 1'b0, 32'h01, 32'h0, 2'b01, 1'b0, 0, rd);
        transact("err_sz11", 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 0, rd);
        transact("err_lw400", 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 0, rd);
        transact("err_sw12", 1'b1, 32'h12, 32'hFFFF_FFFF, 2'b10, 1'b0, 0, rd);
        transact("err_sh11", 1'b1, 32'h11, 32'hFFFF_FFFF, 2'b01, 1'b0, 0, rd);
        transact("err_ss11", 1'b1, 32'h10, 32'hFFFF_FFFF, 2'b11, 1'b0, 0, rd);
        transact("err_sb400", 1'b1, 32'h410, 32'hFFFF_FFFF, 2'b00, 1'b0, 0, rd);
        transact("lw_10c", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd);
        chk("lw_10c:const", rd, 32'hDEAD_55EF);

        transact("hold5", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, rd);

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      r_addr = 32'h400 + 32'($urandom_range(0, 1023));
            else if (sel == 1) r_addr = $urandom | 32'h8000_0000;
            else               r_addr = 32'($urandom_range(0, 63));
            r_size = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            transact("rand", 1'($urandom), r_addr, $urandom, r_size, 1'($urandom),
                     $urandom_range(0, 2), rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
